// File: rtl/sum_serie_ctrl.sv
// Multi-nibble adder: one shared 4-bit ripple adder, one nibble per clock, LSB nibble first.
// The carry between nibbles is held in a register.

module Sum4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; s/co hold the last result
// RUN   | one nibble added per edge, NIB edges in total
// DONE  | one-cycle done pulse; start here begins the next operation at once
module sum_serie_ctrl #(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4*NIB-1:0] a,
   input  logic [4*NIB-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [4*NIB-1:0] s,
   output logic             co
);
   localparam int W  = 4 * NIB;
   localparam int CW = $clog2(NIB + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   ra_q, ra_d;
   logic [W-1:0]   rb_q, rb_d;
   logic [W-1:0]   rs_q, rs_d;
   logic           rc_q, rc_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   s_q, s_d;
   logic           co_q, co_d;

   logic [3:0]     nib_sum;
   logic           nib_co;

   Sum4bit u_add (
      .a  (ra_q[3:0]),
      .b  (rb_q[3:0]),
      .ci (rc_q),
      .s  (nib_sum),
      .co (nib_co)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rs_q    <= '0;
         rc_q    <= 1'b0;
         cnt_q   <= '0;
         s_q     <= '0;
         co_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rs_q    <= rs_d;
         rc_q    <= rc_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         co_q    <= co_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rs_d    = rs_q;
      rc_d    = rc_q;
      cnt_d   = cnt_q;
      s_d     = s_q;
      co_d    = co_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               rc_d    = ci;
               rs_d    = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            ra_d  = ra_q >> 4;
            rb_d  = rb_q >> 4;
            // New nibble enters at the top so that after NIB shifts nibble 0 sits at [3:0].
            rs_d  = rs_q >> 4;
            rs_d[W-1 -: 4] = nib_sum;
            rc_d  = nib_co;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(NIB - 1)) begin
               s_d     = rs_d;
               co_d    = nib_co;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign s    = s_q;
   assign co   = co_q;
endmodule

// File: tb/tb_sum_serie_ctrl.sv
// Directed bench for sum_serie_ctrl: NIB=4 scenarios plus an exhaustive NIB=1 sweep.

module tb_sum_serie_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, ci4, busy4, done4, co4;
   logic [15:0] a4, b4, s4;
   logic        start1, ci1, busy1, done1, co1;
   logic [3:0]  a1, b1, s1;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sum_serie_ctrl #(.NIB(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .ci(ci4),
      .busy(busy4), .done(done4), .s(s4), .co(co4)
   );

   sum_serie_ctrl #(.NIB(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
      .busy(busy1), .done(done1), .s(s1), .co(co1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF; ci4 = 1'b1;
      start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
      tick(); tick(); tick();
      n_chk++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy4); end
      n_chk++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", done4); end
      n_chk++; if (s4 !== 16'h0000) begin n_bad++; $display("FAIL reset_s got=%h exp=0000", s4); end
      n_chk++; if (co4 !== 1'b0) begin n_bad++; $display("FAIL reset_co got=%b exp=0", co4); end
      n_chk++; if ({busy1, done1, co1, s1} !== 7'd0) begin n_bad++; $display("FAIL reset_nib1 got=%b exp=0", {busy1, done1, co1, s1}); end
      start4 = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_add();
      a4 = 16'h1234; b4 = 16'h4321; ci4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0; a4 = 16'h0F0F; b4 = 16'hF0F0; ci4 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         n_chk++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin n_bad++; $display("FAIL basic_busy cyc=%0d got busy=%b done=%b exp busy=1 done=0", k, busy4, done4); end
         tick();
      end
      n_chk++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin n_bad++; $display("FAIL basic_done got done=%b busy=%b exp done=1 busy=0", done4, busy4); end
      n_chk++; if (s4 !== 16'h5556 || co4 !== 1'b0) begin n_bad++; $display("FAIL basic_sum got=%b_%h exp=0_5556", co4, s4); end
      tick();
      n_chk++; if (done4 !== 1'b0 || s4 !== 16'h5556) begin n_bad++; $display("FAIL basic_hold got done=%b s=%h exp done=0 s=5556", done4, s4); end
   endtask

   task automatic test_carry_ripple();
      a4 = 16'hFFFF; b4 = 16'h0001; ci4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick(); tick(); tick(); tick();
      n_chk++; if (done4 !== 1'b1) begin n_bad++; $display("FAIL ripple_done got=%b exp=1", done4); end
      n_chk++; if (s4 !== 16'h0000 || co4 !== 1'b1) begin n_bad++; $display("FAIL ripple_sum got=%b_%h exp=1_0000", co4, s4); end
      tick();
   endtask

   task automatic test_ignore_busy();
      int   n_done;
      logic [15:0] s_seen;
      logic        co_seen;
      n_done = 0; s_seen = 'x; co_seen = 1'bx;
      a4 = 16'h00FF; b4 = 16'h0001; ci4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      a4 = 16'hAAAA; b4 = 16'h5555; ci4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done4 === 1'b1) begin n_done++; s_seen = s4; co_seen = co4; end
         tick();
      end
      n_chk++; if (n_done != 1) begin n_bad++; $display("FAIL ignore_pulses got=%0d exp=1", n_done); end
      n_chk++; if (s_seen !== 16'h0100 || co_seen !== 1'b0) begin n_bad++; $display("FAIL ignore_sum got=%b_%h exp=0_0100", co_seen, s_seen); end
   endtask

   task automatic test_back_to_back();
      int gap;
      a4 = 16'h1234; b4 = 16'h4321; ci4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick(); tick(); tick(); tick();
      n_chk++; if (done4 !== 1'b1 || s4 !== 16'h5556) begin n_bad++; $display("FAIL b2b_first got done=%b s=%h exp done=1 s=5556", done4, s4); end
      a4 = 16'h8000; b4 = 16'h8000; ci4 = 1'b1; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      n_chk++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL b2b_nogap got busy=%b exp=1", busy4); end
      gap = 1;
      while (done4 !== 1'b1 && gap < 20) begin tick(); gap++; end
      n_chk++; if (gap != 5) begin n_bad++; $display("FAIL b2b_latency got=%0d exp=5", gap); end
      n_chk++; if (s4 !== 16'h0001 || co4 !== 1'b1) begin n_bad++; $display("FAIL b2b_sum got=%b_%h exp=1_0001", co4, s4); end
      tick();
   endtask

   task automatic test_reset_mid_run();
      int n_done;
      n_done = 0;
      a4 = 16'h7777; b4 = 16'h1111; ci4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      n_chk++; if ({busy4, done4, co4, s4} !== 19'd0) begin n_bad++; $display("FAIL midrst_clear got busy=%b done=%b co=%b s=%h exp all 0", busy4, done4, co4, s4); end
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (done4 === 1'b1) n_done++;
         tick();
      end
      n_chk++; if (n_done != 0) begin n_bad++; $display("FAIL midrst_nodone got=%0d exp=0", n_done); end
      a4 = 16'h0001; b4 = 16'h0002; ci4 = 1'b0; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick(); tick(); tick(); tick();
      n_chk++; if (done4 !== 1'b1 || s4 !== 16'h0003 || co4 !== 1'b0) begin n_bad++; $display("FAIL midrst_after got done=%b co=%b s=%h exp done=1 co=0 s=0003", done4, co4, s4); end
      tick();
   endtask

   task automatic test_nib1_sweep();
      logic [4:0] exp_sum;
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               a1 = 4'(ia); b1 = 4'(ib); ci1 = 1'(ic); start1 = 1'b1;
               exp_sum = 5'(ia + ib + ic);
               tick();
               start1 = 1'b0;
               n_chk++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin n_bad++; $display("FAIL nib1_busy a=%h b=%h ci=%0d got busy=%b done=%b exp busy=1 done=0", ia, ib, ic, busy1, done1); end
               tick();
               n_chk++; if (done1 !== 1'b1 || {co1, s1} !== exp_sum) begin n_bad++; $display("FAIL nib1_sum a=%h b=%h ci=%0d got done=%b sum=%h exp done=1 sum=%h", ia, ib, ic, done1, {co1, s1}, exp_sum); end
            end
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_run();
      test_nib1_sweep();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule

// File: doc/sum_serie_ctrl.md
# sum_serie_ctrl

Sequential multi-nibble adder controller. Reuses a single instance of the existing 4-bit ripple adder `Sum4bit` to add two operands of 4·NIB bits, one nibble per clock, least-significant nibble first. A registered carry links successive nibbles. Sits between a requester and the shared 4-bit adder and owns its sequencing through a start/busy/done handshake.

## Interface

Parameters:
- NIB, default 4: number of nibbles per operand; operand width W = 4·NIB. Legal range 1..8.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  W  operand A; sampled on the accepting edge only.
- b  input  W  operand B; sampled on the accepting edge only.
- ci  input  1  carry-in of the whole addition; sampled with a/b.
- busy  output  1  high while the operation is in progress (state RUN).
- done  output  1  one-cycle pulse; result valid.
- s  output  W  sum; registered.
- co  output  1  final carry-out; registered.

## Operation

- One clock; reset is synchronous and active-low. While rst_n=0 at an edge: state←IDLE, busy=0, done=0, s=0, co=0, internal registers cleared.
- Internal registers:
  - ra, rb: W-bit shift registers for the operands.
  - rs: W-bit accumulating sum.
  - rc: 1-bit carry.
  - cnt: nibble counter, width ceil(log2(NIB+1)).
- Datapath: `Sum4bit` inputs are ra[3:0], rb[3:0], rc. Each RUN edge:
  - ra and rb shift right by 4.
  - The adder's 4-bit sum enters rs at the top; rs shifts right by 4.
  - rc ← adder carry-out; cnt increments.
- Exactly NIB RUN edges, so the final rs holds nibble 0 at [3:0].
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → load ra←a, rb←b, rc←ci, cnt←0, rs←0; go to RUN. start=0 → stay.
  - RUN: busy=1. Process one nibble per edge. On the edge where cnt reaches NIB−1 processed→NIB: s←final rs, co←final adder carry; go to DONE. start is ignored in RUN; a/b/ci changes have no effect.
  - DONE: done=1, busy=0, for exactly one cycle. start=1 → accept a new operation as from IDLE (back-to-back). Otherwise go to IDLE.
- s and co change only on the edge entering DONE (or at reset). They hold their value through IDLE until the next completion.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(W+1), unsigned. No overflow flag.

## Timing

- Accepting edge E0. RUN edges E1..E_NIB. done=1 and s/co valid during the cycle after E_NIB. busy=1 during the cycles after E0..E_(NIB−1).
- Latency start→done: NIB+1 cycles (NIB=4 → 5).
- Throughput with back-to-back starts: one result every NIB+1 cycles.
- Combinational path per cycle: one 4-bit ripple (4 FA stages). No combinational path from inputs to outputs.
- Reset mid-RUN: the operation is aborted; no done pulse; s/co forced to 0. The next start is served normally.
- start and rst_n=0 at the same edge: reset wins.
- start held high continuously: one operation accepted per IDLE/DONE visit.

## Test plan

- NIB=4, a=16'h1234, b=16'h4321, ci=1 → done 5 cycles after the start edge; s=16'h5556, co=0; busy high for exactly 4 cycles.
- NIB=4, a=16'hFFFF, b=16'h0001, ci=0 → s=16'h0000, co=1. The carry must ripple across all four nibble cycles.
- NIB=4, first start a=16'h00FF, b=16'h0001, ci=0; pulse start with a=16'hAAAA while busy → the second request is ignored; s=16'h0100, co=0; exactly one done pulse.
- NIB=4, start in the DONE cycle with a=16'h8000, b=16'h8000, ci=1 → the new operation starts with no IDLE gap; second done 5 cycles later; s=16'h0001, co=1.
- NIB=4, assert rst_n=0 two cycles after start → busy, done, s and co are 0 on the next edge; no done pulse. A subsequent a=1, b=2, ci=0 gives s=3.
- NIB=1, exhaustive sweep of all 512 (a,b,ci) combinations → {co,s} equals a+b+ci for every case; done after 2 cycles each.
